// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up: index counter (clk_i, reset_i, clear_i, up_i -> count_o) that returns to init on clear and wraps at max_val_p
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
module bsg_counter_clear_up #(
  parameter int max_val_p = 1,
  parameter int init_val_p = 0,
  localparam int w_lp = `BSG_SAFE_CLOG2(max_val_p + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clear_i,
  input  logic            up_i,
  output logic [w_lp-1:0] count_o
);
  always_ff @(posedge clk_i)
    count_o <= (reset_i | clear_i) ? w_lp'(init_val_p)
             : up_i ? ((count_o == w_lp'(max_val_p)) ? '0 : count_o + w_lp'(1))
             : count_o;
endmodule

// File: rtl/bsg_array_serializer.sv
// bsg_array_serializer: captures a flat array (data_i/valid_i/ready_o) and emits one element per yumi (data_o/valid_o/yumi_i) on clk_i with sync reset_i
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif
module bsg_array_serializer #(
  parameter int width_p = 32,
  parameter int els_p = 5,
  parameter int hi_to_lo_p = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p*els_p-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic                     valid_o,
  input  logic                     yumi_i
);
  localparam int lg_els_lp = `BSG_SAFE_CLOG2(els_p);
  localparam logic [lg_els_lp-1:0] cnt_max_lp = lg_els_lp'(els_p - 1);
  typedef enum logic {idle, send} state_e;
  state_e state_r, state_n;
  logic [lg_els_lp-1:0] cnt, idx;
  logic [width_p*els_p-1:0] data_r;
  logic take, last, accept;
  assign take = yumi_i & (state_r == send);
  assign last = cnt == cnt_max_lp;
  assign accept = valid_i & ready_o;
  always_ff @(posedge clk_i)
    state_r <= reset_i ? idle : state_n;
  always_comb
    state_n = accept ? send : (take & last) ? idle : state_r;
  always_comb begin
    ready_o = ~reset_i & ((state_r == idle) | (take & last));
    valid_o = ~reset_i & (state_r == send);
  end
  always_ff @(posedge clk_i)
    if (accept) data_r <= data_i;
  bsg_counter_clear_up #(.max_val_p(els_p - 1), .init_val_p(0)) u_cnt (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .clear_i(accept | (take & last)),
    .up_i(take & ~last),
    .count_o(cnt)
  );
  assign idx = (hi_to_lo_p != 0) ? cnt_max_lp - cnt : cnt;
  always_comb begin
    data_o = data_r[width_p-1:0];
    for (int k = 1; k < els_p; k++)
      if (idx == lg_els_lp'(k)) data_o = data_r[k*width_p +: width_p];
  end
endmodule

// File: tb/tb_bsg_array_serializer.sv
// tb_bsg_array_serializer: table-driven handshake vectors with data scoreboards for lo/hi order and els_p=1 streaming
module tb_bsg_array_serializer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset_i = 1, valid_i = 0, yumi_i = 0;
  logic [159:0] data_i = '0;
  logic ready0, valid0, ready1, valid1;
  logic [31:0] data0, data1;
  logic valid2_i = 0, yumi2_i = 0;
  logic [7:0] data2_i = '0, data2;
  logic ready2, valid2;
  bsg_array_serializer u0 (.clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready0), .data_o(data0), .valid_o(valid0), .yumi_i(yumi_i));
  bsg_array_serializer #(.hi_to_lo_p(1)) u1 (.clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready1), .data_o(data1), .valid_o(valid1), .yumi_i(yumi_i));
  bsg_array_serializer #(.width_p(8), .els_p(1)) u2 (.clk_i(clk), .reset_i(reset_i), .data_i(data2_i), .valid_i(valid2_i),
    .ready_o(ready2), .data_o(data2), .valid_o(valid2), .yumi_i(yumi2_i));
  typedef struct packed {logic r, v, y, er, ev;} vec_t;
  vec_t tbl[$];
  logic [31:0] q0[$], q1[$], q2[$];
  int pass_n = 0, tot = 0, arr_n = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask
  task automatic add(input logic r, v, y, er, ev, input int n = 1);
    repeat (n) tbl.push_back('{r, v, y, er, ev});
  endtask
  function automatic logic [159:0] mk(input int n);
    logic [159:0] a;
    for (int k = 0; k < 5; k++) a[k*32 +: 32] = n * 256 + k;
    return a;
  endfunction
  task automatic sb(input string name, input logic [31:0] act, input logic y, inout logic [31:0] q[$]);
    if (q.size() == 0) begin
      tot++;
      $display("FAIL %s: got %0h with empty scoreboard want no output", name, act);
    end else begin
      check(name, act, q[0]);
      if (y) void'(q.pop_front());
    end
  endtask
  initial begin
    add(1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 4); add(0, 0, 1, 1, 1); add(0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0); add(0, 1, 1, 0, 1, 4); add(0, 1, 1, 1, 1); add(0, 0, 1, 0, 1, 4); add(0, 0, 1, 1, 1); add(0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0);
    repeat (4) begin add(0, 0, 0, 0, 1); add(0, 0, 1, 0, 1); end
    add(0, 0, 0, 0, 1); add(0, 0, 1, 1, 1); add(0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 2); add(1, 0, 0, 0, 0); add(0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0); add(0, 0, 1, 0, 1, 4); add(0, 0, 1, 1, 1);
    add(0, 0, 1, 1, 0); add(0, 1, 1, 1, 0); add(0, 0, 1, 0, 1, 4); add(0, 0, 1, 1, 1); add(0, 0, 0, 1, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset_i = tbl[i].r; valid_i = tbl[i].v; yumi_i = tbl[i].y; data_i = mk(arr_n);
      #1;
      check($sformatf("ready0[%0d]", i), 32'(ready0), 32'(tbl[i].er));
      check($sformatf("valid0[%0d]", i), 32'(valid0), 32'(tbl[i].ev));
      check($sformatf("ready1[%0d]", i), 32'(ready1), 32'(tbl[i].er));
      check($sformatf("valid1[%0d]", i), 32'(valid1), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        sb($sformatf("data0[%0d]", i), data0, tbl[i].y, q0);
        sb($sformatf("data1[%0d]", i), data1, tbl[i].y, q1);
      end
      if (tbl[i].v & tbl[i].er) begin
        for (int k = 0; k < 5; k++) begin
          q0.push_back(arr_n * 256 + k);
          q1.push_back(arr_n * 256 + 4 - k);
        end
        arr_n++;
      end
      if (tbl[i].r) begin q0.delete(); q1.delete(); end
    end
    check("sb0_drained", q0.size(), 0);
    check("sb1_drained", q1.size(), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valid_i = 0; yumi_i = 0;
      valid2_i = i < 4; yumi2_i = i > 0 && i < 5; data2_i = 8'(8'hA0 + i);
      #1;
      check($sformatf("ready2[%0d]", i), 32'(ready2), 1);
      check($sformatf("valid2[%0d]", i), 32'(valid2), 32'(i > 0 && i < 5));
      if (i > 0 && i < 5) sb($sformatf("data2[%0d]", i), 32'(data2), 1'b1, q2);
      if (valid2_i) q2.push_back(32'(data2_i));
    end
    check("sb2_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
